// File: rtl/dmem_arb_pkg.sv
// Shared encodings for the data-memory arbiter: FSM state and read-owner tags.
package dmem_arb_pkg;

  typedef enum logic {
    ARB_RR     = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  typedef enum logic {
    OWN_CORE = 1'b0,
    OWN_HOST = 1'b1
  } owner_e;

  function automatic owner_e other_owner(owner_e o);
    return (o == OWN_CORE) ? OWN_HOST : OWN_CORE;
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester, lock and memory-side signals of the data-memory arbiter.
interface dmem_arbiter_if #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 32
);
  logic              core_req;
  logic              core_we;
  logic [ADDR_W-1:0] core_addr;
  logic [DATA_W-1:0] core_wdata;
  logic              core_gnt;
  logic              core_stall;
  logic              core_rvalid;
  logic [DATA_W-1:0] core_rdata;

  logic              host_req;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_gnt;
  logic              host_rvalid;
  logic [DATA_W-1:0] host_rdata;
  logic              host_lock;
  logic              lock_timeout;

  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_data;
  logic              mem_wren;
  logic [DATA_W-1:0] mem_q;

  // Arbiter side.
  modport slave (
    input  core_req, core_we, core_addr, core_wdata,
    output core_gnt, core_stall, core_rvalid, core_rdata,
    input  host_req, host_we, host_addr, host_wdata, host_lock,
    output host_gnt, host_rvalid, host_rdata, lock_timeout,
    output mem_address, mem_data, mem_wren,
    input  mem_q
  );

  // Requesters plus the memory.
  modport master (
    output core_req, core_we, core_addr, core_wdata,
    input  core_gnt, core_stall, core_rvalid, core_rdata,
    output host_req, host_we, host_addr, host_wdata, host_lock,
    input  host_gnt, host_rvalid, host_rdata, lock_timeout,
    input  mem_address, mem_data, mem_wren,
    output mem_q
  );

endinterface

// File: rtl/dmem_rd_tracker.sv
// Remembers who issued the read accepted last cycle and steers mem_q to that requester.
module dmem_rd_tracker
  import dmem_arb_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              gnt,
  input  logic              we,
  input  owner_e            owner,
  input  logic [DATA_W-1:0] mem_q,
  output logic              core_rvalid,
  output logic [DATA_W-1:0] core_rdata,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata
);

  logic   rd_pend_q;
  owner_e rd_owner_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_pend_q  <= 1'b0;
      rd_owner_q <= OWN_CORE;
    end else begin
      rd_pend_q  <= gnt & ~we;
      rd_owner_q <= owner;
    end
  end

  // Gated by rst so nothing leaks out while reset is asserted.
  always_comb begin
    core_rvalid = rst & rd_pend_q & (rd_owner_q == OWN_CORE);
    host_rvalid = rst & rd_pend_q & (rd_owner_q == OWN_HOST);
    core_rdata  = core_rvalid ? mem_q : '0;
    host_rdata  = host_rvalid ? mem_q : '0;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Core/host arbiter for the single-port data memory, with a host lock that the core
// can break after LOCK_MAX waiting cycles.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned LOCK_MAX = 256
) (
  input logic           clk,
  input logic           rst,
  dmem_arbiter_if.slave bus
);

  localparam int unsigned CntW = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;
  localparam logic [CntW-1:0] WaitLast = CntW'(LOCK_MAX - 1);

  arb_state_e        state_q;
  owner_e            prio_q;
  logic [CntW-1:0]   wait_cnt_q;
  logic              lock_timeout_q;

  logic              core_gnt;
  logic              host_gnt;
  logic              gnt_we;
  owner_e            gnt_owner;
  logic [ADDR_W-1:0] addr_sel;
  logic [DATA_W-1:0] wdata_sel;

  always_comb begin
    core_gnt = 1'b0;
    host_gnt = 1'b0;
    if (rst) begin
      if (state_q == ARB_LOCKED) begin
        host_gnt = bus.host_req;
      end else if (bus.core_req && bus.host_req) begin
        core_gnt = (prio_q == OWN_CORE);
        host_gnt = (prio_q == OWN_HOST);
      end else begin
        core_gnt = bus.core_req;
        host_gnt = bus.host_req;
      end
    end
  end

  // With no grant the memory sees the core's address/data.
  always_comb begin
    addr_sel  = host_gnt ? bus.host_addr  : bus.core_addr;
    wdata_sel = host_gnt ? bus.host_wdata : bus.core_wdata;
    gnt_we    = (core_gnt & bus.core_we) | (host_gnt & bus.host_we);
    gnt_owner = host_gnt ? OWN_HOST : OWN_CORE;
  end

  assign bus.mem_address  = addr_sel;
  assign bus.mem_data     = wdata_sel;
  assign bus.mem_wren     = gnt_we;
  assign bus.core_gnt     = core_gnt;
  assign bus.host_gnt     = host_gnt;
  assign bus.core_stall   = rst & bus.core_req & ~core_gnt;
  assign bus.lock_timeout = rst & lock_timeout_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= ARB_RR;
      prio_q         <= OWN_CORE;
      wait_cnt_q     <= '0;
      lock_timeout_q <= 1'b0;
    end else begin
      unique case (state_q)
        ARB_RR: begin
          wait_cnt_q <= '0;
          if (core_gnt || host_gnt) prio_q <= other_owner(gnt_owner);
          if (host_gnt && bus.host_lock) state_q <= ARB_LOCKED;
        end
        ARB_LOCKED: begin
          if (!bus.host_lock) begin
            state_q    <= ARB_RR;
            wait_cnt_q <= '0;
          end else if (bus.core_req) begin
            // Core has waited long enough: break the lock and hand it priority.
            if (wait_cnt_q == WaitLast) begin
              state_q        <= ARB_RR;
              wait_cnt_q     <= '0;
              lock_timeout_q <= 1'b1;
              prio_q         <= OWN_CORE;
            end else begin
              wait_cnt_q <= wait_cnt_q + 1'b1;
            end
          end else begin
            wait_cnt_q <= '0;
          end
        end
        default: state_q <= ARB_RR;
      endcase
    end
  end

  dmem_rd_tracker #(
    .DATA_W(DATA_W)
  ) u_rd_tracker (
    .clk        (clk),
    .rst        (rst),
    .gnt        (core_gnt | host_gnt),
    .we         (gnt_we),
    .owner      (gnt_owner),
    .mem_q      (bus.mem_q),
    .core_rvalid(bus.core_rvalid),
    .core_rdata (bus.core_rdata),
    .host_rvalid(bus.host_rvalid),
    .host_rdata (bus.host_rdata)
  );

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed scenarios plus a randomized run against a behavioural arbiter model.
module tb_dmem_arbiter;

  localparam int unsigned AW    = 10;
  localparam int unsigned DW    = 32;
  localparam int unsigned LockA = 256;
  localparam int unsigned LockB = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus0 ();
  dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LOCK_MAX(LockA)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0)
  );
  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LOCK_MAX(LockB)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1)
  );

  // data_mem_ip stand-ins: one-cycle read latency, write at the edge.
  logic [DW-1:0] mem0 [0:1023];
  logic [DW-1:0] mem1 [0:1023];
  always @(posedge clk) begin
    if (bus0.mem_wren) mem0[bus0.mem_address] <= bus0.mem_data;
    bus0.mem_q <= mem0[bus0.mem_address];
    if (bus1.mem_wren) mem1[bus1.mem_address] <= bus1.mem_data;
    bus1.mem_q <= mem1[bus1.mem_address];
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus0.core_req = 0; bus0.core_we = 0; bus0.core_addr = '0; bus0.core_wdata = '0;
    bus0.host_req = 0; bus0.host_we = 0; bus0.host_addr = '0; bus0.host_wdata = '0;
    bus0.host_lock = 0;
    bus1.core_req = 0; bus1.core_we = 0; bus1.core_addr = '0; bus1.core_wdata = '0;
    bus1.host_req = 0; bus1.host_we = 0; bus1.host_addr = '0; bus1.host_wdata = '0;
    bus1.host_lock = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 0;
    bus0.core_req = 1; bus0.core_addr = 10'h155; bus0.core_wdata = 32'hA5A5_0001;
    bus0.host_req = 1; bus0.host_we = 1; bus0.host_addr = 10'h0AA;
    next_cycle();
    @(negedge clk);
    n_tests++; if (bus0.core_gnt !== 1'b0) begin n_fail++;
      $display("FAIL rst_core_gnt: got %b want 0", bus0.core_gnt); end
    n_tests++; if (bus0.host_gnt !== 1'b0) begin n_fail++;
      $display("FAIL rst_host_gnt: got %b want 0", bus0.host_gnt); end
    n_tests++; if (bus0.mem_wren !== 1'b0) begin n_fail++;
      $display("FAIL rst_wren: got %b want 0", bus0.mem_wren); end
    n_tests++; if (bus0.core_rvalid !== 1'b0 || bus0.host_rvalid !== 1'b0) begin n_fail++;
      $display("FAIL rst_rvalid: got %b%b want 00", bus0.core_rvalid, bus0.host_rvalid); end
    n_tests++; if (bus0.lock_timeout !== 1'b0) begin n_fail++;
      $display("FAIL rst_timeout: got %b want 0", bus0.lock_timeout); end
    n_tests++; if (bus0.mem_address !== 10'h155 || bus0.mem_data !== 32'hA5A5_0001) begin
      n_fail++;
      $display("FAIL rst_passthru: got %h/%h want 155/a5a50001", bus0.mem_address,
               bus0.mem_data); end
    next_cycle();
    idle_inputs();
    rst = 1;
  endtask

  task automatic test_core_read();
    bus0.host_req = 1; bus0.host_we = 1; bus0.host_addr = 10'h010;
    bus0.host_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    n_tests++; if (bus0.host_gnt !== 1'b1 || bus0.mem_wren !== 1'b1) begin n_fail++;
      $display("FAIL cr_preload: got gnt %b wren %b want 1 1", bus0.host_gnt, bus0.mem_wren);
    end
    next_cycle();
    idle_inputs();
    bus0.core_req = 1; bus0.core_addr = 10'h010;
    @(negedge clk);
    n_tests++; if (bus0.core_gnt !== 1'b1 || bus0.core_stall !== 1'b0) begin n_fail++;
      $display("FAIL cr_gnt: got gnt %b stall %b want 1 0", bus0.core_gnt, bus0.core_stall);
    end
    next_cycle();
    idle_inputs();
    @(negedge clk);
    n_tests++; if (bus0.core_rvalid !== 1'b1 || bus0.core_rdata !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL cr_rdata: got %b %h want 1 deadbeef", bus0.core_rvalid, bus0.core_rdata);
    end
    n_tests++; if (bus0.host_rvalid !== 1'b0) begin n_fail++;
      $display("FAIL cr_host_rvalid: got %b want 0", bus0.host_rvalid); end
    next_cycle();
  endtask

  task automatic test_contention();
    logic exp_c;
    rst = 0;
    next_cycle();
    rst = 1;
    bus0.core_req = 1; bus0.core_addr = 10'h010;
    bus0.host_req = 1; bus0.host_addr = 10'h010;
    for (int i = 0; i < 4; i++) begin
      exp_c = (i % 2 == 0);
      @(negedge clk);
      n_tests++; if (bus0.core_gnt !== exp_c || bus0.host_gnt !== !exp_c) begin n_fail++;
        $display("FAIL cont_gnt%0d: got %b%b want %b%b", i, bus0.core_gnt, bus0.host_gnt,
                 exp_c, !exp_c); end
      n_tests++; if (bus0.core_stall !== !exp_c) begin n_fail++;
        $display("FAIL cont_stall%0d: got %b want %b", i, bus0.core_stall, !exp_c); end
      if (i > 0) begin
        n_tests++; if (bus0.core_rvalid !== !exp_c || bus0.host_rvalid !== exp_c) begin
          n_fail++;
          $display("FAIL cont_rvalid%0d: got %b%b want %b%b", i, bus0.core_rvalid,
                   bus0.host_rvalid, !exp_c, exp_c); end
      end
      next_cycle();
    end
    idle_inputs();
    @(negedge clk);
    n_tests++; if (bus0.host_rvalid !== 1'b1 || bus0.host_rdata !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL cont_last: got %b %h want 1 deadbeef", bus0.host_rvalid, bus0.host_rdata);
    end
    next_cycle();
  endtask

  task automatic test_fwd();
    bus0.host_req = 1; bus0.host_we = 1; bus0.host_addr = 10'h3FF;
    bus0.host_wdata = 32'h1234_5678;
    @(negedge clk);
    n_tests++; if (bus0.host_gnt !== 1'b1) begin n_fail++;
      $display("FAIL fwd_wr_gnt: got %b want 1", bus0.host_gnt); end
    next_cycle();
    idle_inputs();
    bus0.core_req = 1; bus0.core_addr = 10'h3FF;
    @(negedge clk);
    n_tests++; if (bus0.core_gnt !== 1'b1) begin n_fail++;
      $display("FAIL fwd_rd_gnt: got %b want 1", bus0.core_gnt); end
    next_cycle();
    idle_inputs();
    @(negedge clk);
    n_tests++; if (bus0.core_rvalid !== 1'b1 || bus0.core_rdata !== 32'h1234_5678) begin
      n_fail++;
      $display("FAIL fwd_rdata: got %b %h want 1 12345678", bus0.core_rvalid, bus0.core_rdata);
    end
    next_cycle();
  endtask

  task automatic test_lock();
    bus0.host_req = 1; bus0.host_lock = 1; bus0.host_addr = 10'h3FF;
    @(negedge clk);
    n_tests++; if (bus0.host_gnt !== 1'b1) begin n_fail++;
      $display("FAIL lock_gnt: got %b want 1", bus0.host_gnt); end
    next_cycle();
    bus0.host_req = 0;
    bus0.core_req = 1; bus0.core_addr = 10'h010;
    for (int i = 0; i < 5; i++) begin
      bus0.host_req = (i == 2); bus0.host_we = 1; bus0.host_addr = 10'h020;
      bus0.host_wdata = 32'hCAFE_0002;
      @(negedge clk);
      n_tests++; if (bus0.core_gnt !== 1'b0 || bus0.core_stall !== 1'b1) begin n_fail++;
        $display("FAIL lock_hold%0d: got gnt %b stall %b want 0 1", i, bus0.core_gnt,
                 bus0.core_stall); end
      if (i == 0) begin
        n_tests++; if (bus0.host_rvalid !== 1'b1 || bus0.host_rdata !== 32'h1234_5678) begin
          n_fail++;
          $display("FAIL lock_rd: got %b %h want 1 12345678", bus0.host_rvalid,
                   bus0.host_rdata); end
      end
      if (i == 2) begin
        n_tests++; if (bus0.host_gnt !== 1'b1) begin n_fail++;
          $display("FAIL lock_host_wr: got %b want 1", bus0.host_gnt); end
      end
      next_cycle();
    end
    bus0.host_req = 0; bus0.host_lock = 0;
    @(negedge clk);
    n_tests++; if (bus0.core_gnt !== 1'b0) begin n_fail++;
      $display("FAIL lock_release_edge: got %b want 0", bus0.core_gnt); end
    next_cycle();
    @(negedge clk);
    n_tests++; if (bus0.core_gnt !== 1'b1 || bus0.lock_timeout !== 1'b0) begin n_fail++;
      $display("FAIL lock_after: got gnt %b to %b want 1 0", bus0.core_gnt, bus0.lock_timeout);
    end
    next_cycle();
    idle_inputs();
    @(negedge clk);
    n_tests++; if (bus0.core_rvalid !== 1'b1 || bus0.core_rdata !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL lock_core_rd: got %b %h want 1 deadbeef", bus0.core_rvalid,
               bus0.core_rdata); end
    next_cycle();
  endtask

  task automatic test_timeout();
    bus1.host_req = 1; bus1.host_lock = 1;
    @(negedge clk);
    n_tests++; if (bus1.host_gnt !== 1'b1) begin n_fail++;
      $display("FAIL to_lock_gnt: got %b want 1", bus1.host_gnt); end
    next_cycle();
    bus1.host_req = 0;
    bus1.core_req = 1;
    for (int i = 0; i < int'(LockB); i++) begin
      @(negedge clk);
      n_tests++; if (bus1.core_gnt !== 1'b0 || bus1.lock_timeout !== 1'b0) begin n_fail++;
        $display("FAIL to_wait%0d: got gnt %b to %b want 0 0", i, bus1.core_gnt,
                 bus1.lock_timeout); end
      next_cycle();
    end
    @(negedge clk);
    n_tests++; if (bus1.core_gnt !== 1'b1 || bus1.lock_timeout !== 1'b1) begin n_fail++;
      $display("FAIL to_break: got gnt %b to %b want 1 1", bus1.core_gnt, bus1.lock_timeout);
    end
    next_cycle();
    bus1.core_req = 0; bus1.host_lock = 0;
    @(negedge clk);
    n_tests++; if (bus1.lock_timeout !== 1'b1) begin n_fail++;
      $display("FAIL to_sticky: got %b want 1", bus1.lock_timeout); end
    next_cycle();
  endtask

  task automatic test_reset_mid_read();
    bus0.host_req = 1; bus0.host_lock = 1; bus0.host_addr = 10'h010;
    next_cycle();
    rst = 0;
    bus0.host_lock = 0; bus0.host_addr = 10'h020;
    bus0.core_req = 1; bus0.core_addr = 10'h3FF;
    @(negedge clk);
    n_tests++; if (bus0.core_gnt !== 1'b0 || bus0.host_gnt !== 1'b0) begin n_fail++;
      $display("FAIL rmr_gnt: got %b%b want 00", bus0.core_gnt, bus0.host_gnt); end
    n_tests++; if (bus0.host_rvalid !== 1'b0) begin n_fail++;
      $display("FAIL rmr_rvalid_in_rst: got %b want 0", bus0.host_rvalid); end
    next_cycle();
    rst = 1;
    @(negedge clk);
    n_tests++; if (bus0.core_rvalid !== 1'b0 || bus0.host_rvalid !== 1'b0) begin n_fail++;
      $display("FAIL rmr_rvalid: got %b%b want 00", bus0.core_rvalid, bus0.host_rvalid); end
    n_tests++; if (bus0.core_gnt !== 1'b1 || bus0.host_gnt !== 1'b0) begin n_fail++;
      $display("FAIL rmr_prio: got %b%b want 10", bus0.core_gnt, bus0.host_gnt); end
    n_tests++; if (bus1.lock_timeout !== 1'b0) begin n_fail++;
      $display("FAIL rmr_to_clear: got %b want 0", bus1.lock_timeout); end
    next_cycle();
    bus0.core_req = 0;
    @(negedge clk);
    n_tests++; if (bus0.core_rvalid !== 1'b1 || bus0.core_rdata !== 32'h1234_5678) begin
      n_fail++;
      $display("FAIL rmr_rd: got %b %h want 1 12345678", bus0.core_rvalid, bus0.core_rdata);
    end
    n_tests++; if (bus0.host_gnt !== 1'b1) begin n_fail++;
      $display("FAIL rmr_host_gnt: got %b want 1", bus0.host_gnt); end
    next_cycle();
    idle_inputs();
  endtask

  // Randomized traffic against a model of the arbitration rules.
  task automatic test_random();
    bit          locked = 0, prio_core = 1, timed_out = 0;
    int          waited = 0;
    logic [31:0] gm [8];
    bit          gv [8];
    bit          ev_c = 0, ev_h = 0, ed_known = 0;
    logic [31:0] ed = '0;
    bit          c_pend = 0, c_we = 0, h_pend = 0, h_we = 0, lock, wc, wh, creq;
    logic [2:0]  c_addr = '0, h_addr = '0;
    logic [31:0] c_wd = '0, h_wd = '0;
    for (int k = 0; k < 8; k++) gv[k] = 0;
    idle_inputs();
    rst = 0;
    next_cycle();
    rst = 1;
    for (int n = 0; n < 400; n++) begin
      if (!c_pend && $urandom_range(0, 1) == 1) begin
        c_pend = 1; c_we = 1'($urandom_range(0, 1));
        c_addr = 3'($urandom_range(0, 7)); c_wd = $urandom;
      end
      if (!h_pend && $urandom_range(0, 1) == 1) begin
        h_pend = 1; h_we = 1'($urandom_range(0, 1));
        h_addr = 3'($urandom_range(0, 7)); h_wd = $urandom;
      end
      lock = ($urandom_range(0, 3) != 0);
      bus0.core_req = c_pend; bus0.core_we = c_we; bus0.core_addr = {7'd0, c_addr};
      bus0.core_wdata = c_wd;
      bus0.host_req = h_pend; bus0.host_we = h_we; bus0.host_addr = {7'd0, h_addr};
      bus0.host_wdata = h_wd; bus0.host_lock = lock;
      if (locked) begin
        wc = 0; wh = h_pend;
      end else if (c_pend && h_pend) begin
        wc = prio_core; wh = !prio_core;
      end else begin
        wc = c_pend; wh = h_pend;
      end
      @(negedge clk);
      n_tests++; if (bus0.core_gnt !== wc || bus0.host_gnt !== wh) begin n_fail++;
        $display("FAIL rnd_gnt@%0d: got %b%b want %b%b", n, bus0.core_gnt, bus0.host_gnt,
                 wc, wh); end
      n_tests++; if (bus0.mem_wren !== ((wc && c_we) || (wh && h_we))) begin n_fail++;
        $display("FAIL rnd_wren@%0d: got %b", n, bus0.mem_wren); end
      n_tests++; if (bus0.core_rvalid !== ev_c || bus0.host_rvalid !== ev_h) begin n_fail++;
        $display("FAIL rnd_rvalid@%0d: got %b%b want %b%b", n, bus0.core_rvalid,
                 bus0.host_rvalid, ev_c, ev_h); end
      if (ev_c && ed_known) begin
        n_tests++; if (bus0.core_rdata !== ed) begin n_fail++;
          $display("FAIL rnd_core_rdata@%0d: got %h want %h", n, bus0.core_rdata, ed); end
      end
      if (ev_h && ed_known) begin
        n_tests++; if (bus0.host_rdata !== ed) begin n_fail++;
          $display("FAIL rnd_host_rdata@%0d: got %h want %h", n, bus0.host_rdata, ed); end
      end
      n_tests++; if (bus0.lock_timeout !== timed_out) begin n_fail++;
        $display("FAIL rnd_timeout@%0d: got %b want %b", n, bus0.lock_timeout, timed_out); end
      creq = c_pend;
      ev_c = wc && !c_we;
      ev_h = wh && !h_we;
      if (wc) begin
        if (c_we) begin gm[c_addr] = c_wd; gv[c_addr] = 1; end
        else begin ed = gm[c_addr]; ed_known = gv[c_addr]; end
        c_pend = 0;
      end
      if (wh) begin
        if (h_we) begin gm[h_addr] = h_wd; gv[h_addr] = 1; end
        else begin ed = gm[h_addr]; ed_known = gv[h_addr]; end
        h_pend = 0;
      end
      if (!locked) begin
        if (wc) prio_core = 0;
        if (wh) prio_core = 1;
        if (wh && lock) begin locked = 1; waited = 0; end
      end else if (!lock) begin
        locked = 0; waited = 0;
      end else if (creq) begin
        if (waited == int'(LockA) - 1) begin
          locked = 0; waited = 0; timed_out = 1; prio_core = 1;
        end else begin
          waited++;
        end
      end else begin
        waited = 0;
      end
      next_cycle();
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rst = 0;
    next_cycle();
    test_reset();
    test_core_read();
    test_contention();
    test_fwd();
    test_lock();
    test_timeout();
    test_reset_mid_read();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
